// File: rtl/uart_rx.sv
// 16x-oversampling UART receiver (8N1 by default, LSB first) with a two-flop input
// synchronizer, a one-clock valid pulse per good frame and a framing-error pulse.
module uart_rx #(
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned NO_OF_SAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 baud_en_rx,
  input  logic                 rx,
  output logic                 rx_active,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err
);

  localparam int unsigned TW = $clog2(NO_OF_SAMPLE);
  localparam int unsigned BW = $clog2(DATA_BITS + 1);

  localparam logic [TW-1:0] TICK_MID  = TW'(NO_OF_SAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(NO_OF_SAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  state_t               state_q, state_d;
  logic                 rx_meta, rx_s;
  logic [TW-1:0]        tick_q, tick_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 stop_sample;
  logic                 valid_d, ferr_d;

  // Line idles high, so the synchronizer resets to 1 to avoid a false start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      tick_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      rx_valid  <= valid_d;
      frame_err <= ferr_d;
      if (valid_d) begin
        rx_data <= shift_q;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    unique case (state_q)
      IDLE: begin
        tick_d = '0;
        if (!rx_s) begin
          state_d = START;
        end
      end
      START: begin
        if (baud_en_rx) begin
          if (tick_q == TICK_MID) begin
            tick_d  = '0;
            bit_d   = '0;
            state_d = rx_s ? IDLE : DATA;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (baud_en_rx) begin
          if (tick_q == TICK_LAST) begin
            tick_d  = '0;
            shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
            bit_d   = bit_q + 1'b1;
            if (bit_q == BIT_LAST) begin
              state_d = STOP;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (baud_en_rx) begin
          if (tick_q == TICK_LAST) begin
            tick_d  = '0;
            state_d = rx_s ? IDLE : BREAK;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      BREAK: begin
        // A held-low line must return high before another start edge counts.
        if (rx_s) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rx_active   = (state_q == START) || (state_q == DATA) || (state_q == STOP);
    stop_sample = (state_q == STOP) && baud_en_rx && (tick_q == TICK_LAST);
    valid_d     = stop_sample && rx_s;
    ferr_d      = stop_sample && !rx_s;
  end

endmodule
